// File: rtl/psa_pkg.sv
// Shared constants and elaboration helpers for the pipelined segment adder.
package psa_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_N = 4;

    function automatic int num_stages(input int w, input int n);
        return w / n;
    endfunction

    // Evaluated at elaboration; a false result stops the build.
    function automatic bit width_ok(input int w, input int n);
        return (n > 0) && (w >= n) && ((w % n) == 0);
    endfunction

endpackage

// File: rtl/psa_stage.sv
// One pipeline stage: registers the incoming state, then adds segment K.
// With PSA_CARRY_CUT_EN defined, only the top stage forwards its carry-out.
module psa_stage
    import psa_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N,
    parameter int K = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   adv,
    input  logic                   valid_d,
    input  logic                   carry_d,
    input  logic [2*W-K*N-1:0]     z_d,
    output logic                   valid_q,
    output logic                   carry_nx,
    output logic [2*W-K*N-N-1:0]   z_nx
);

    localparam int S  = num_stages(W, N);
    localparam int ZW = 2*W - K*N;

    // z_q = {remaining b slices, remaining a slices, completed sum slices};
    // the low W bits hold a above bit K*N and the sum below it.
    logic            carry_q;
    logic [ZW-1:0]   z_q;
    logic [N-1:0]    seg_sum;
    logic            seg_co;
    logic [W-1:0]    x_nx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            z_q     <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            z_q     <= z_d;
        end
    end

    rca_block #(.N(N)) u_rca (
        .a  (z_q[K*N +: N]),
        .b  (z_q[W +: N]),
        .ci (carry_q),
        .s  (seg_sum),
        .co (seg_co)
    );

    always_comb begin
        x_nx            = z_q[W-1:0];
        x_nx[K*N +: N]  = seg_sum;
    end

    if (K == S-1) begin : g_last
        assign z_nx = x_nx;
    end else begin : g_mid
        assign z_nx = {z_q[ZW-1:W+N], x_nx};
    end

`ifdef PSA_CARRY_CUT_EN
    assign carry_nx = (K == S-1) ? seg_co : 1'b0;
`else
    assign carry_nx = seg_co;
`endif

endmodule

// File: rtl/rca_block.sv
// N-bit ripple-carry adder used as the per-stage segment adder.
module rca_block #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[N];

endmodule

// File: rtl/pipelined_segment_adder.sv
// W-bit adder resolved N bits per clock across W/N stages, elastic valid/ready.
// Optional PSA_CARRY_CUT_EN turns it into a block-based approximate adder.
module pipelined_segment_adder
    import psa_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    localparam int S = num_stages(W, N);

    if (!width_ok(W, N)) begin : g_cfg_err
        $fatal(1, "pipelined_segment_adder: W must be a positive multiple of N");
    end

    // Handshake: a beat moves on a rising edge where valid & ready are both 1.
    // The whole pipe shifts together when the output is empty or being taken,
    // so ready_o depends only on valid_o and ready_i; outputs hold while stalled.
    logic         adv;
    logic         last_valid;
    logic         last_carry;
    logic [W-1:0] last_sum;

    assign adv     = ~valid_o | ready_i;
    assign ready_o = adv;

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic                 valid_d;
        logic                 carry_d;
        logic                 valid_q;
        logic                 carry_nx;
        logic [2*W-k*N-1:0]   z_d;
        logic [2*W-k*N-N-1:0] z_nx;

        if (k == 0) begin : g_head
            assign valid_d = valid_i;
            assign carry_d = c_i;
            assign z_d     = {b_i, a_i};
        end else begin : g_link
            assign valid_d = g_stage[k-1].valid_q;
            assign carry_d = g_stage[k-1].carry_nx;
            assign z_d     = g_stage[k-1].z_nx;
        end

        psa_stage #(.W(W), .N(N), .K(k)) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .adv      (adv),
            .valid_d  (valid_d),
            .carry_d  (carry_d),
            .z_d      (z_d),
            .valid_q  (valid_q),
            .carry_nx (carry_nx),
            .z_nx     (z_nx)
        );

        if (k == S-1) begin : g_tail
            assign last_valid = valid_q;
            assign last_carry = carry_nx;
            assign last_sum   = z_nx;
        end
    end

    // Data only loads with a valid beat so bubbles never show on s_o/c_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            s_o     <= '0;
            c_o     <= 1'b0;
        end else if (adv) begin
            valid_o <= last_valid;
            if (last_valid) begin
                s_o <= last_sum;
                c_o <= last_carry;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder; honours PSA_CARRY_CUT_EN.
module tb_pipelined_segment_adder;

    localparam int W = 16;
    localparam int N = 4;
    localparam int S = W / N;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         c_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] s_o;
    logic         c_o;

    logic [W:0]   exp_q[$];
    bit           chk_q[$];
    int           acc_q[$];

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    bit           chk_lat = 1'b0;
    bit           hold_v = 1'b0;
    logic [W+1:0] hold_val = '0;
    logic [W:0]   out_ref = '0;
    logic [W:0]   last_out = '0;
    int           present_cyc = 0;
    int           pop_cnt = 0;
    int           pop_first = 0;
    int           pop_last = 0;

    pipelined_segment_adder dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .s_o     (s_o),
        .c_o     (c_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        logic [W:0] r;
`ifdef PSA_CARRY_CUT_EN
        int seg;
        r = '0;
        for (int k = 0; k < S; k++) begin
            seg = int'(a[k*N +: N]) + int'(b[k*N +: N]) + ((k == 0) ? int'(c) : 0);
            r[k*N +: N] = seg[N-1:0];
            if (k == S-1) r[W] = seg[N];
        end
`else
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            chk_q.delete();
            acc_q.delete();
            hold_v  = 1'b0;
            out_ref = '0;
        end else begin
            check("ready_rule", {1'b0, ready_o}, {1'b0, (!valid_o || ready_i)});
            if (hold_v)
                check("stall_hold", {valid_o, c_o, s_o}, hold_val);
            if (!valid_o)
                check("idle_outputs", {1'b0, c_o, s_o}, {1'b0, out_ref});
            if (valid_o && !hold_v)
                present_cyc = cyc;
            hold_v   = valid_o && !ready_i;
            hold_val = {valid_o, c_o, s_o};
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {1'b0, c_o, s_o}, '1);
                end else begin
                    logic [W:0] e;
                    bit         lc;
                    int         ac;
                    e  = exp_q.pop_front();
                    lc = chk_q.pop_front();
                    ac = acc_q.pop_front();
                    check("result", {1'b0, c_o, s_o}, {1'b0, e});
                    if (lc)
                        check("latency", (W+2)'(present_cyc - ac - 1), (W+2)'(S));
                    out_ref  = e;
                    last_out = {c_o, s_o};
                    if (pop_cnt == 0) pop_first = cyc;
                    pop_last = cyc;
                    pop_cnt++;
                end
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(ref_sum(a_i, b_i, c_i));
                chk_q.push_back(chk_lat);
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit chk);
        bit done;
        done    = 1'b0;
        a_i     = a;
        b_i     = b;
        c_i     = c;
        chk_lat = chk;
        valid_i = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (ready_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        chk_lat = 1'b0;
        if (!done) timeout("send_accept");
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || valid_o) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("reset_outputs", {valid_o, c_o, s_o}, '0);
        check("reset_ready", {1'b0, ready_o}, {1'b0, 1'b1});
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Full carry propagation across every segment
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_drain();
`ifdef PSA_CARRY_CUT_EN
        check("dir_ffff", {1'b0, last_out}, {1'b0, 17'h0_FFF0});
`else
        check("dir_ffff", {1'b0, last_out}, {1'b0, 17'h1_0000});
`endif

        // Carry-in crossing a segment boundary
        send(16'h00FF, 16'h0000, 1'b1, 1'b1);
        wait_drain();
`ifdef PSA_CARRY_CUT_EN
        check("dir_cin", {1'b0, last_out}, {1'b0, 17'h0_00F0});
`else
        check("dir_cin", {1'b0, last_out}, {1'b0, 17'h0_0100});
`endif

        // Back-to-back stream
        pop_cnt = 0;
        for (int i = 0; i < 8; i++)
            send(16'(i), 16'(2*i), 1'b0, 1'b1);
        wait_drain();
        check("stream_count", (W+2)'(pop_cnt), (W+2)'(8));
        check("stream_span", (W+2)'(pop_last - pop_first), (W+2)'(7));

        // Backpressure with a full output
        pop_cnt = 0;
        ready_i = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'hF00D, 16'h0FF3, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        begin
            int t;
            t = 0;
            while (!valid_o && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) timeout("bp_output");
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        wait_drain();
        check("bp_count", (W+2)'(pop_cnt), (W+2)'(3));

        // Reset with transactions in flight
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        send(16'h7777, 16'h1111, 1'b1, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("flush_outputs", {valid_o, c_o, s_o}, '0);
        send(16'h1234, 16'h4321, 1'b1, 1'b1);
        wait_drain();
        check("post_reset", {1'b0, last_out}, {1'b0, 17'h0_5556});

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            a_i     = W'($urandom);
            b_i     = W'($urandom);
            c_i     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        wait_drain();
        check("queue_empty", (W+2)'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_segment_adder.md
# pipelined_segment_adder

Pipelined W-bit adder that splits the operands into W/N segments of N bits and resolves one segment per clock stage. Each stage is a `rca_block` instance. The inter-segment carry is registered between stages, operand slices are skewed forward and sum slices deskewed back into a full word. It sits between the operand source and the result consumer in the datapath and gives a one-result-per-cycle elastic valid/ready interface, with the carry chain length bounded to N bits per cycle.

## Interface
- W, 16: total operand width; must be a multiple of N
- N, 4: segment width = width of each `rca_block` stage
- S (derived, W/N): number of pipeline stages; not overridable
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  input operands valid
- ready_o  out  1  block accepts input this cycle
- a_i  in  W  operand A
- b_i  in  W  operand B
- c_i  in  1  carry-in to segment 0
- valid_o  out  1  s_o/c_o hold a result
- ready_i  in  1  consumer accepts result this cycle
- s_o  out  W  sum
- c_o  out  1  carry-out of top segment

## Operation
- Advance condition: adv = ~valid_o | ready_i. The whole pipeline shifts together when adv=1 and holds otherwise (global stall, no bubbles squeezed).
- ready_o = adv (combinational). Input is accepted on valid_i & ready_o.
- Stage k (k=0..S-1) holds a valid bit, a carry register, remaining operand slices [W-1:kN], and completed sum slices [kN-1:0].
- Stage k adds a[kN+N-1:kN] + b[...] + carry_k through `rca_block`. It writes the sum slice, passes carry-out to stage k+1 and passes the remaining slices unchanged.
- carry_0 = c_i, captured with the operands.
- The output register takes the stage S-1 result. c_o = carry-out of segment S-1.
- Invalid stages still shift but carry valid=0. Their data contents are don't-care and must not reach the outputs while valid_o=0.
- Arithmetic is modulo 2^W, with the overflow bit on c_o. Operands are unsigned, and no sign handling is done.
- Reset: all valid bits 0, valid_o=0, s_o=0, c_o=0, all carry registers 0; ready_o=1 in the first cycle after reset. Transactions in flight at reset are discarded silently.
- rst_i overrides adv and any simultaneous accept.

## Timing
- Latency: S cycles from accept to valid_o, which is 4 for the defaults. Throughput is 1 result per cycle with ready_i held high.
- Outputs are registered. ready_o is the only combinational output, and it depends on valid_o and ready_i only.
- Backpressure: while valid_o=1 and ready_i=0, s_o, c_o and valid_o hold stable, ready_o=0, and no input is accepted.
- When the output is consumed and a new input is accepted in the same cycle, both happen; there is no lost or duplicated beat.
- Critical path: one N-bit ripple chain plus the mux into the stage register.

## Configuration
- `PSA_CARRY_CUT_EN` defined: every inter-segment carry (carry_1..carry_{S-1}) is forced to 0. This gives a block-based approximate adder; c_i still enters segment 0. c_o is the carry-out of the top segment computed with carry-in 0.
- Latency, handshake and register count are identical with or without the macro, so the configurations swap without retiming the surrounding design.
- Undefined: exact addition.

## Structure
- Shared package `psa_pkg`:
  - a function computing S from W and N;
  - an elaboration-time check constant for W % N == 0. A violating configuration must be a hard elaboration error.
- One sub-module, `psa_stage`, parameterised by W, N and stage index. It holds one `rca_block`, the stage valid/carry/slice registers and the adv enable. The top level generates S of these plus the output register and handshake.

## Test plan
- Exact mode (W=16, N=4), a=0xFFFF, b=0x0001, c_i=0, ready_i=1 -> exactly 4 cycles later valid_o=1, s_o=0x0000, c_o=1.
- Same stimulus with `PSA_CARRY_CUT_EN` defined -> s_o=0xFFF0, c_o=0, at the same 4-cycle latency.
- a=0x00FF, b=0x0000, c_i=1 -> s_o=0x0100, c_o=0, showing c_i ripples across a segment boundary via the carry register.
- Stream 8 back-to-back operand pairs (i, 2i) for i=0..7 with ready_i=1 -> 8 consecutive valid_o cycles with s_o=3i in order, and ready_o=1 throughout.
- Hold ready_i=0 for 5 cycles while a result is at the output -> s_o/c_o/valid_o stable and ready_o=0. Release -> all queued results emerge in order with none dropped or duplicated.
- Assert rst_i for one cycle with 3 transactions in flight -> valid_o=0, s_o=0, c_o=0 on the next cycle. None of the flushed results ever appears, and a fresh operand pair completes after 4 cycles.
